// File: rtl/ram_loader.sv
// Serial-boot loader: builds big-endian words from a framed byte stream, writes each to RAM and reads it back.
// The CPU is held off the RAM port for the whole frame. Checksum, verify and inter-byte timeout faults are flagged.
module ram_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] ram_in,
  output logic        ram_load_bar,
  output logic [15:0] ram_address,
  input  logic [15:0] ram_value,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
    S_WRITE, S_VERIFY_RD, S_VERIFY_CMP, S_CSUM, S_FINISH
  } state_t;

  state_t      r_state, w_state_next;
  logic [15:0] r_cur_addr, r_remaining, r_word, r_timer;
  logic [7:0]  r_hi_byte, r_csum;
  logic        r_err;
  logic [1:0]  r_err_code;

  logic        w_xfer, w_wait, w_timeout, w_verify_ok;
  logic [15:0] w_timer_inc, w_len;
  logic [7:0]  w_csum_add;

  assign w_xfer      = rx_valid && rx_ready;
  assign w_wait      = (r_state inside {S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO,
                                        S_DATA_HI, S_DATA_LO, S_CSUM});
  assign w_timer_inc = r_timer + 16'd1;
  assign w_timeout   = w_wait && !w_xfer && (w_timer_inc == LP_TIMEOUT);
  assign w_csum_add  = r_csum + rx_data;
  assign w_len       = {r_hi_byte, rx_data};
  assign w_verify_ok = (ram_value == r_word);

  assign ram_address = r_cur_addr;
  assign ram_in      = r_word;
  assign cpu_hold    = (r_state != S_IDLE);
  assign err         = r_err;
  assign err_code    = r_err_code;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    rx_ready     = 1'b0;
    ram_load_bar = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        rx_ready = 1'b1;
        if (w_xfer && rx_data == SYNC_BYTE) w_state_next = S_ADDR_HI;
      end
      S_ADDR_HI: begin rx_ready = 1'b1; if (w_xfer) w_state_next = S_ADDR_LO; end
      S_ADDR_LO: begin rx_ready = 1'b1; if (w_xfer) w_state_next = S_LEN_HI;  end
      S_LEN_HI:  begin rx_ready = 1'b1; if (w_xfer) w_state_next = S_LEN_LO;  end
      S_LEN_LO: begin
        rx_ready = 1'b1;
        if (w_xfer) w_state_next = (w_len == 16'd0) ? S_CSUM : S_DATA_HI;
      end
      S_DATA_HI: begin rx_ready = 1'b1; if (w_xfer) w_state_next = S_DATA_LO; end
      S_DATA_LO: begin rx_ready = 1'b1; if (w_xfer) w_state_next = S_WRITE;   end
      S_WRITE: begin
        ram_load_bar = 1'b0;
        w_state_next = S_VERIFY_RD;
      end
      S_VERIFY_RD: w_state_next = S_VERIFY_CMP;
      S_VERIFY_CMP: begin
        if (!w_verify_ok)              w_state_next = S_IDLE;
        else if (r_remaining == 16'd1) w_state_next = S_CSUM;
        else                           w_state_next = S_DATA_HI;
      end
      S_CSUM: begin
        rx_ready = 1'b1;
        if (w_xfer) w_state_next = (rx_data == r_csum) ? S_FINISH : S_IDLE;
      end
      S_FINISH: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_timeout) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_word      <= '0;
      r_timer     <= '0;
      r_hi_byte   <= '0;
      r_csum      <= '0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      // Idle gaps are only timed while a byte is actually awaited.
      if (r_state == S_IDLE || w_xfer) r_timer <= '0;
      else if (w_wait)                 r_timer <= w_timer_inc;

      if (w_xfer) begin
        case (r_state)
          S_IDLE: if (rx_data == SYNC_BYTE) begin
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_csum     <= '0;
          end
          S_ADDR_HI, S_LEN_HI: begin
            r_hi_byte <= rx_data;
            r_csum    <= w_csum_add;
          end
          S_ADDR_LO: begin
            r_cur_addr <= w_len;
            r_csum     <= w_csum_add;
          end
          S_LEN_LO: begin
            r_remaining <= w_len;
            r_csum      <= w_csum_add;
          end
          S_DATA_HI: begin
            r_word[15:8] <= rx_data;
            r_csum       <= w_csum_add;
          end
          S_DATA_LO: begin
            r_word[7:0] <= rx_data;
            r_csum      <= w_csum_add;
          end
          S_CSUM: if (rx_data != r_csum) begin
            r_err      <= 1'b1;
            r_err_code <= 2'b01;
          end
          default: ;
        endcase
      end

      if (r_state == S_VERIFY_CMP) begin
        if (w_verify_ok) begin
          r_cur_addr  <= r_cur_addr + 16'd1;
          r_remaining <= r_remaining - 16'd1;
        end else begin
          r_err      <= 1'b1;
          r_err_code <= 2'b10;
        end
      end

      if (w_timeout) begin
        r_err      <= 1'b1;
        r_err_code <= 2'b11;
      end
    end
  end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
Serial-boot loader sitting directly upstream of the 16-bit, 256-word block RAM on its write port.
- Consumes a framed byte stream from the UART receiver and assembles big-endian 16-bit words.
- Writes each word into RAM through the active-low load strobe, then reads it back and verifies it.
- Holds the CPU off the RAM port (cpu_hold) while a frame is in progress.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker accepted in IDLE.
- TIMEOUT, 65535, max cycles between accepted bytes mid-frame before abort (counter width 16).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid this cycle.
- rx_ready  out  1  loader can accept a byte; a transfer occurs when rx_valid && rx_ready.
- ram_in  out  16  write data to RAM.
- ram_load_bar  out  1  active-low RAM write strobe; RAM writes at posedge when low.
- ram_address  out  16  RAM address; RAM decodes [7:0] only.
- ram_value  in  16  RAM registered read data, valid one cycle after the address is presented.
- cpu_hold  out  1  high while the frame is in progress (not IDLE).
- done  out  1  one-cycle pulse on successful frame.
- err  out  1  sticky error flag.
- err_code  out  2  01 checksum, 10 verify mismatch, 11 timeout; 00 when err=0.

Behaviour:
- Reset values: state IDLE, rx_ready=1, ram_load_bar=1, ram_address=0, ram_in=0, cpu_hold=0, done=0, err=0, err_code=00. Internal address, count, checksum and timeout registers are cleared.
- Reset mid-frame: the next cycle is IDLE, load_bar=1, and no partial write occurs.
- Frame format: SYNC, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, then LEN words as (HI, LO) byte pairs, then CSUM.
  - CSUM = 8-bit sum mod 256 of the four header bytes and all data bytes.
  - LEN is counted in words.
- States: IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, VERIFY_RD, VERIFY_CMP, CSUM, FINISH.
- IDLE:
  - A transfer with rx_data==SYNC_BYTE moves to ADDR_HI, clears err/err_code, and zeroes the checksum.
  - Any other byte is consumed and ignored.
- Header states: each accepted byte is captured and added to the checksum, advancing one state per byte.
- After LEN_LO: go to DATA_HI if LEN!=0, else to CSUM.
- DATA_HI: captures word[15:8].
- DATA_LO: captures word[7:0], then goes to WRITE.
- rx_ready=1 in IDLE, header, DATA and CSUM states; rx_ready=0 in WRITE, VERIFY_RD, VERIFY_CMP and FINISH.
- WRITE (1 cycle): ram_load_bar=0, ram_address=cur_addr, ram_in=word.
- VERIFY_RD (1 cycle): ram_load_bar=1, ram_address=cur_addr.
- VERIFY_CMP (1 cycle): compare ram_value against word.
  - Mismatch: latch err=1 and err_code=10, then go to IDLE.
  - Match: cur_addr+=1 (wraps 16'hFFFF->0) and remaining-=1; go to CSUM if remaining==0, else DATA_HI.
- Throughput: each word costs exactly 3 non-accepting cycles after its LO byte.
- ram_load_bar is low only in WRITE, never for more than one consecutive cycle.
- CSUM:
  - Match: go to FINISH, which pulses done=1 for one cycle, then IDLE.
  - Mismatch: err=1, err_code=01, then IDLE.
  - Words already written remain in RAM.
- Timeout: the counter resets on every accepted byte and in IDLE. It increments in header, DATA and CSUM states. On reaching TIMEOUT: err=1, err_code=11, go to IDLE.
- cpu_hold=1 in every state except IDLE, including the cycle of FINISH.
- A SYNC byte received mid-frame is treated as ordinary data; there is no resync.
- LEN up to 65535 is accepted; the address wraps modulo 2^16.

Test Plan:
- Basic load: bytes A5,00,10,00,02,12,34,AB,CD,D0 -> RAM[0x10]=0x1234 and RAM[0x11]=0xABCD; each write is a single load_bar-low cycle; done pulses once; err=0; cpu_hold is high from the cycle after A5 until IDLE.
- Bad checksum: same frame with CSUM=D1 -> both words written, err=1, err_code=01, no done pulse; the next A5 clears err.
- Zero length: A5,00,20,00,00,20 -> no load_bar-low cycle, done pulse, err=0.
- Verify fault: RAM model forced to return 0xFFFF at address 0x10, basic frame sent -> err_code=10 after the first word; no write to 0x11.
- Timeout and backpressure:
  - With TIMEOUT=16: send A5,00 then idle 16 cycles -> err_code=11, return to IDLE.
  - Driving rx_valid every cycle -> rx_ready low for exactly 3 cycles after each LO byte, and no byte is lost.
- Reset mid-frame and noise: assert reset during the VERIFY_RD of the second word -> next cycle ram_load_bar=1 and cpu_hold=0. Non-A5 bytes sent in IDLE cause no state change.
